// File: rtl/sha_256_pkg.sv
// Shared types and constants for the SHA-256 block controller and its hash-state datapath.
package sha_256_pkg;

  localparam int BLOCK_W = 512;
  localparam int ROUNDS  = 64;
  localparam int RND_W   = 6;

  // The scheduler wraps after round 63, so the terminal index is fixed by ROUNDS.
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_UPDATE = 2'd3
  } ctrl_state_t;

  localparam logic [31:0] H0 = 32'h6a09e667;
  localparam logic [31:0] H1 = 32'hbb67ae85;
  localparam logic [31:0] H2 = 32'h3c6ef372;
  localparam logic [31:0] H3 = 32'ha54ff53a;
  localparam logic [31:0] H4 = 32'h510e527f;
  localparam logic [31:0] H5 = 32'h9b05688c;
  localparam logic [31:0] H6 = 32'h1f83d9ab;
  localparam logic [31:0] H7 = 32'h5be0cd19;

  function automatic logic [255:0] sha_256_iv();
    return {H0, H1, H2, H3, H4, H5, H6, H7};
  endfunction

endpackage

// File: rtl/sha_256_round_counter.sv
// Round index counter: clears on block acceptance, counts while enabled, flags round 63.
module sha_256_round_counter
  import sha_256_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [RND_W-1:0] o_rnd,
  output logic             o_term
);

  logic [RND_W-1:0] r_rnd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rnd <= '0;
    end else if (i_clr) begin
      r_rnd <= '0;
    end else if (i_en) begin
      r_rnd <= r_rnd + 1'b1;
    end
  end

  assign o_rnd  = r_rnd;
  assign o_term = (r_rnd == RND_LAST);

endmodule

// File: rtl/sha_256_block_controller.sv
// SHA-256 block sequencer: accepts blocks, runs 64 scheduler rounds, strobes init/update/digest.
// Optional SHA_256_CTRL_PERF_EN adds accepted-block and completed-message counters.
module sha_256_block_controller
  import sha_256_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  // Handshake: a block transfers on a rising edge where i_blk_valid && o_blk_ready;
  // the producer holds i_blk_data/i_blk_last stable until that edge.
  input  logic               i_blk_valid,
  output logic               o_blk_ready,
  input  logic [BLOCK_W-1:0] i_blk_data,
  input  logic               i_blk_last,
  output logic [BLOCK_W-1:0] o_sched_block,
  output logic               o_sched_en,
  output logic               o_cmp_en,
  output logic [RND_W-1:0]   o_cmp_round,
  output logic               o_hash_init,
  output logic               o_hash_update,
  output logic               o_digest_valid,
`ifdef SHA_256_CTRL_PERF_EN
  output logic [31:0]        o_blk_count,
  output logic [15:0]        o_msg_count,
`endif
  output logic [1:0]         o_dbg_state
);

  ctrl_state_t        r_state;
  ctrl_state_t        w_state_nxt;
  logic [BLOCK_W-1:0] r_block;
  logic               r_first;
  logic               r_last;
  logic               r_cmp_en;
  logic [RND_W-1:0]   r_cmp_round;
  logic               w_rnd_clr;
  logic               w_rnd_en;
  logic               w_rnd_term;
  logic [RND_W-1:0]   w_rnd;
  logic               w_accept;

  sha_256_round_counter u_rnd (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_rnd_clr),
    .i_en   (w_rnd_en),
    .o_rnd  (w_rnd),
    .o_term (w_rnd_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    o_blk_ready    = 1'b0;
    o_sched_en     = 1'b0;
    o_hash_init    = 1'b0;
    o_hash_update  = 1'b0;
    o_digest_valid = 1'b0;
    w_rnd_clr      = 1'b0;
    w_rnd_en       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        o_blk_ready = 1'b1;
        if (i_blk_valid) begin
          o_hash_init = r_first;
          w_rnd_clr   = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        o_sched_en = 1'b1;
        // Hold at 63 instead of wrapping; DRAIN lets the last compression round land.
        if (w_rnd_term) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_rnd_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        o_hash_update  = 1'b1;
        o_digest_valid = r_last;
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && i_blk_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_block     <= '0;
      r_last      <= 1'b0;
      r_first     <= 1'b1;
      r_cmp_en    <= 1'b0;
      r_cmp_round <= '0;
    end else begin
      if (w_accept) begin
        r_block <= i_blk_data;
        r_last  <= i_blk_last;
      end
      if (r_state == ST_UPDATE) begin
        r_first <= r_last;
      end
      // The scheduler registers W, so compression strobes trail the enable by one cycle.
      r_cmp_en    <= o_sched_en;
      r_cmp_round <= w_rnd;
    end
  end

  assign o_sched_block = r_block;
  assign o_cmp_en      = r_cmp_en;
  assign o_cmp_round   = r_cmp_round;
  assign o_dbg_state   = r_state;

`ifdef SHA_256_CTRL_PERF_EN
  logic [31:0] r_blk_count;
  logic [15:0] r_msg_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk_count <= '0;
      r_msg_count <= '0;
    end else begin
      if (w_accept) begin
        r_blk_count <= r_blk_count + 32'd1;
      end
      if (o_digest_valid) begin
        r_msg_count <= r_msg_count + 16'd1;
      end
    end
  end

  assign o_blk_count = r_blk_count;
  assign o_msg_count = r_msg_count;
`endif

endmodule

// File: tb/tb_sha_256_block_controller.sv
// Bench for sha_256_block_controller: timeline model per block plus a SHA-256 reference for digests.
`timescale 1ns/1ps
module tb_sha_256_block_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_last;
  logic [511:0] blk_data;
  logic         blk_ready;
  logic [511:0] sched_block;
  logic         sched_en;
  logic         cmp_en;
  logic [5:0]   cmp_round;
  logic         hash_init;
  logic         hash_update;
  logic         digest_valid;
  logic [1:0]   dbg_state;
`ifdef SHA_256_CTRL_PERF_EN
  logic [31:0]  blk_count;
  logic [15:0]  msg_count;
`endif

  always #5 clk = ~clk;

  sha_256_block_controller dut (
    .clk            (clk),
    .rst            (rst),
    .i_blk_valid    (blk_valid),
    .o_blk_ready    (blk_ready),
    .i_blk_data     (blk_data),
    .i_blk_last     (blk_last),
    .o_sched_block  (sched_block),
    .o_sched_en     (sched_en),
    .o_cmp_en       (cmp_en),
    .o_cmp_round    (cmp_round),
    .o_hash_init    (hash_init),
    .o_hash_update  (hash_update),
    .o_digest_valid (digest_valid),
`ifdef SHA_256_CTRL_PERF_EN
    .o_blk_count    (blk_count),
    .o_msg_count    (msg_count),
`endif
    .o_dbg_state    (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] M2A_BLK = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] M2B_BLK = {{15{32'h0}}, 32'h000001c0};

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] w_word(input logic [511:0] blk, input int t);
    logic [31:0] w [64];
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i <= t; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    return w[t];
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
    logic [255:0] s;
    s = h;
    for (int t = 0; t < 64; t++) s = sha_round(s, w_word(blk, t), k_tab[t]);
    return add8(h, s);
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: block timeline position, message chaining value, and the hash tracked from DUT strobes.
  bit           m_active;
  int           m_k;
  bit           m_first;
  bit           m_last;
  logic [511:0] m_block;
  logic [255:0] m_chain;
  logic [255:0] m_exp_dig;
  int           m_blk_cnt;
  int           m_msg_cnt;
  logic [255:0] hs;
  logic [255:0] ws;
  logic [255:0] last_dig;
  int           dig_cnt = 0;

  always @(negedge clk) begin : cmp_p
    logic       e_ready, e_sen, e_cen, e_init, e_upd, e_dv;
    logic [5:0] e_rnd;
    if (rst) begin
      m_active  = 0;
      m_k       = 0;
      m_first   = 1;
      m_last    = 0;
      m_block   = '0;
      m_chain   = IV;
      m_blk_cnt = 0;
      m_msg_cnt = 0;
      hs        = '0;
      ws        = '0;
    end else begin
      if (m_active) begin
        e_ready = 0;
        e_sen   = (m_k >= 1) && (m_k <= 64);
        e_cen   = (m_k >= 2) && (m_k <= 65);
        e_rnd   = 6'(m_k - 2);
        e_init  = 0;
        e_upd   = (m_k == 66);
        e_dv    = (m_k == 66) && m_last;
      end else begin
        e_ready = 1;
        e_sen   = 0;
        e_cen   = 0;
        e_rnd   = '0;
        e_init  = blk_valid && m_first;
        e_upd   = 0;
        e_dv    = 0;
      end
      check("ctrl{ready,sched_en,cmp_en,init,update,digest}",
            {blk_ready, sched_en, cmp_en, hash_init, hash_update, digest_valid},
            {e_ready, e_sen, e_cen, e_init, e_upd, e_dv});
      if (e_cen) check("cmp_round", cmp_round, e_rnd);
      check("sched_block", sched_block, m_block);

      // Hash state driven purely by the controller's strobes.
      if (hash_init) hs = IV;
      if (cmp_en) begin
        if (cmp_round == 6'd0) ws = hs;
        ws = sha_round(ws, w_word(sched_block, int'(cmp_round)), k_tab[cmp_round]);
      end
      if (hash_update) hs = add8(hs, ws);
      if (digest_valid) begin
        dig_cnt++;
        last_dig = hs;
      end

      if (m_active) begin
        if (m_k == 66) begin
          m_chain = compress(m_chain, m_block);
          if (m_last) begin
            check("digest", hs, m_chain);
            m_exp_dig = m_chain;
            m_msg_cnt++;
          end
          m_first  = m_last;
          m_active = 0;
        end else begin
          m_k++;
        end
      end else if (blk_valid) begin
        if (m_first) m_chain = IV;
        m_block  = blk_data;
        m_last   = blk_last;
        m_active = 1;
        m_k      = 1;
        m_blk_cnt++;
      end
    end
  end

  task automatic send(input logic [511:0] d, input logic l, input bit junk);
    bit got;
    got       = 0;
    blk_data  = d;
    blk_last  = l;
    blk_valid = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (blk_ready) begin
        got = 1;
        break;
      end
    end
    check("handshake_wait", got, 1);
    @(posedge clk);
    #1;
    blk_valid = 0;
    if (junk) begin
      repeat (60) begin
        blk_valid = 1'($urandom_range(0, 1));
        blk_data  = rand_blk();
        blk_last  = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      blk_valid = 0;
    end
  endtask

  task automatic wait_msgs(input int n);
    for (int i = 0; i < 400 && dig_cnt < n; i++) @(posedge clk);
    #1;
    check("messages_completed", dig_cnt, n);
  endtask

  task automatic send_msg(input int nb, input bit junk);
    for (int b = 0; b < nb; b++) send(rand_blk(), (b == nb - 1), junk);
  endtask

  initial begin
    int target;
    rst       = 1;
    blk_valid = 0;
    blk_last  = 0;
    blk_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {blk_ready, sched_en, cmp_en, hash_init, hash_update, digest_valid}, 6'b100000);
    check("reset_cmp_round", cmp_round, 6'd0);
    check("reset_sched_block", sched_block, '0);
    rst = 0;

    send(ABC_BLK, 1, 0);
    wait_msgs(1);
    check("abc_digest", last_dig, ABC_DIG);
    check("abc_model", m_exp_dig, ABC_DIG);

    send(M2A_BLK, 0, 0);
    send(M2B_BLK, 1, 0);
    wait_msgs(2);
    check("two_block_digest", last_dig, TWO_DIG);
    check("two_block_model", m_exp_dig, TWO_DIG);

    // Back-to-back single-block messages with valid held.
    send(ABC_BLK, 1, 0);
    send(rand_blk(), 1, 0);
    wait_msgs(4);

    // Valid and data toggling while the block runs.
    send(rand_blk(), 0, 1);
    send(rand_blk(), 1, 1);
    wait_msgs(5);

    // Reset asserted at round 30.
    send(rand_blk(), 0, 0);
    repeat (30) @(posedge clk);
    #2;
    rst = 1;
    #1;
    check("midrst_ctrl", {blk_ready, sched_en, cmp_en, hash_init, hash_update, digest_valid}, 6'b100000);
    check("midrst_cmp_round", cmp_round, 6'd0);
    check("midrst_sched_block", sched_block, '0);
    @(posedge clk);
    #1;
    rst = 0;
    send(ABC_BLK, 1, 0);
    wait_msgs(6);
    check("abc_after_reset", last_dig, ABC_DIG);

    target = 6;
    for (int m = 0; m < 4; m++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_msg($urandom_range(1, 3), bit'($urandom_range(0, 1)));
      target++;
      wait_msgs(target);
    end

    // Fresh reset, then 3 messages totalling 5 blocks.
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    send_msg(2, 0);
    send_msg(2, 0);
    send_msg(1, 0);
    wait_msgs(target + 3);
    check("model_blocks", m_blk_cnt, 5);
    check("model_msgs", m_msg_cnt, 3);
`ifdef SHA_256_CTRL_PERF_EN
    check("blk_count", blk_count, 32'd5);
    check("msg_count", msg_count, 16'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
